// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencer: streams one raster frame through two line buffers, presents the 3x3
// neighbourhood and latched threshold to the Gradient datapath, registers the returned edge bit.
module sobel_window_ctrl #(
  parameter int unsigned ImgW = 8,
  parameter int unsigned ImgH = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] thr_i,
  input  logic [7:0] pix_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] p0_o,
  output logic [7:0] p1_o,
  output logic [7:0] p2_o,
  output logic [7:0] p3_o,
  output logic [7:0] p4_o,
  output logic [7:0] p5_o,
  output logic [7:0] p6_o,
  output logic [7:0] p7_o,
  output logic [7:0] p8_o,
  output logic [7:0] t_o,
  input  logic       dop_i,
  output logic       edge_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int unsigned CW = $clog2(ImgW);
  localparam int unsigned RW = $clog2(ImgH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            win_v_q, win_v_d;
  logic [7:0]      win_q [9];
  logic [7:0]      win_d [9];
  logic [7:0]      t_q, t_d;
  logic            out_valid_q, out_valid_d;
  logic            edge_q, edge_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      lb0_q [ImgW];
  logic [7:0]      lb1_q [ImgW];

  logic advance, in_ready, accept, last_pix;

  always_comb begin
    advance  = !out_valid_q || out_ready_i;
    in_ready = advance && (state_q == StRun);
    accept   = in_valid_i && in_ready;
    last_pix = (row_q == RW'(ImgH - 1)) && (col_q == CW'(ImgW - 1));

    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    win_v_d      = win_v_q;
    win_d        = win_q;
    t_d          = t_q;
    out_valid_d  = out_valid_q;
    edge_d       = edge_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          t_d     = thr_i;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (accept && last_pix) state_d = StDrain;
      end
      StDrain: begin
        // Wait until the last window has been evaluated and its bit handed off.
        if (!win_v_q && !out_valid_q) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (col_q == CW'(ImgW - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(ImgH - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb0_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_i;
      win_v_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end else if (advance) begin
      win_v_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = win_v_q;
      edge_d      = dop_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      win_v_q      <= 1'b0;
      t_q          <= '0;
      out_valid_q  <= 1'b0;
      edge_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_v_q      <= win_v_d;
      t_q          <= t_d;
      out_valid_q  <= out_valid_d;
      edge_q       <= edge_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers are never cleared; rows 0-1 refill them before any window is valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_i;
    end
  end

  assign in_ready_o   = in_ready;
  assign p0_o         = win_q[0];
  assign p1_o         = win_q[1];
  assign p2_o         = win_q[2];
  assign p3_o         = win_q[3];
  assign p4_o         = win_q[4];
  assign p5_o         = win_q[5];
  assign p6_o         = win_q[6];
  assign p7_o         = win_q[7];
  assign p8_o         = win_q[8];
  assign t_o          = t_q;
  assign edge_o       = edge_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = frame_done_q;

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Frame sequencer for the Sobel edge path. Accepts a raster-order 8-bit pixel stream for one frame, keeps two line buffers, and builds the 3x3 neighbourhood around each interior pixel. It drives that window and a latched threshold into the external Gradient datapath, then registers the returned edge bit onto a valid/ready output stream. It sits between the pixel source and the edge-map sink.

## Interface
- IMG_W, 8: pixels per line; minimum 3.
- IMG_H, 6: lines per frame; minimum 3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- thr_in  in  8  threshold; latched on an accepted start.
- pix_in  in  8  input pixel.
- in_valid  in  1  pix_in valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- P0..P8  out  8 each  window to Gradient.
  - P0/P1/P2: top row, left/mid/right.
  - P3/P4/P5: middle row; P4 is the centre.
  - P6/P7/P8: bottom row.
- T  out  8  latched threshold to Gradient.
- Dop  in  1  combinational edge result from Gradient.
- edge_out  out  1  registered edge bit.
- out_valid  out  1  edge_out valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last edge bit transfers.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start; latch T <= thr_in; row = col = 0.
  - RUN -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DRAIN -> IDLE once the window-valid flag and out_valid are both clear; frame_done pulses on that same cycle.
- start is ignored outside IDLE.
- advance = !out_valid || out_ready.
- in_ready = advance && (state == RUN).
- accept = in_valid && in_ready.
- On accept of pixel (r, c):
  - Read lb1[c] (row r-1) and lb0[c] (row r-2).
  - Write lb0[c] <= lb1[c] and lb1[c] <= pix_in.
  - Window columns shift left: the right column becomes {lb0[c], lb1[c], pix_in} as P2/P5/P8.
  - win_v <= (r >= 2 && c >= 2); this marks the window centred at (r-1, c-1).
  - col increments and wraps at IMG_W-1, incrementing row.
- On advance without accept: win_v <= 0; window registers hold.
- On advance: out_valid <= win_v and edge_out <= Dop.
- With no advance, all pipeline state holds (stall).
- Edge bits are produced for interior pixels only: (IMG_W-2)*(IMG_H-2) bits per frame, in raster order of centre pixel.
- Border pixels yield no output.
- The pixel fed into a window column is always the one at the matching position. Contents of row/column wraps are masked by win_v.
- Line buffers are not cleared; rows 0-1 overwrite them before any window is valid.
- T holds its value through the frame and across IDLE.

## Timing
- Reset (rst_n = 0 at an edge): the following clear to 0.
  - Control: state = IDLE; in_ready, out_valid, edge_out, busy, frame_done.
  - Counters row and col; win_v.
  - Window regs P0..P8 and T.
  - Line buffer contents stay undefined.
- Reset mid-frame aborts the frame with no frame_done; the next start begins cleanly.
- Latency: the window is loaded at the accept edge k; edge_out/out_valid are registered at edge k+1 if out_ready is high or out_valid is low.
- Full throughput: one pixel per cycle while out_ready = 1.
- out_ready low with out_valid high drops in_ready the same cycle. No pixel or bit is lost or duplicated.
- edge_out/out_valid stay stable while stalled.
- busy rises the cycle after the start edge and falls with the frame_done cycle.
- Back-to-back: start is accepted the cycle after frame_done.

## Test plan
- Flat frame: 8x6 frame, all pixels 50, T = 20, in_valid and out_ready held at 1. Expect:
  - exactly 24 out transfers, all edge_out = 0;
  - the first out_valid one cycle after pixel (2,2) is accepted;
  - frame_done once.
- Vertical step: columns 0-3 = 0, columns 4-7 = 200, T = 20. Expect:
  - edge_out = 1 for centre columns 3 and 4;
  - 0 for centre columns 1, 2, 5, 6;
  - this pattern on all 4 interior rows;
  - window check: at the first valid window, P0..P8 equal the pixels at rows 0-2, cols 0-2.
- Backpressure: same step frame with out_ready toggled on a random pattern. Expect:
  - the same 24-bit sequence as the unstalled run;
  - in_ready = 0 on every cycle where out_valid && !out_ready;
  - edge_out is stable during stalls.
- Input gaps: in_valid random at 50%. Expect an identical output sequence and an identical count of 24.
- Control: start pulsed again mid-frame is ignored and T keeps its latched value 20. Expect:
  - rst_n = 0 at pixel (3,1) zeroes all outputs on the next edge;
  - after a new start with T = 250, the step frame gives all 24 bits = 0.
- Boundary size: IMG_W = IMG_H = 3. Expect exactly one output bit, then frame_done, then busy = 0.
